// File: rtl/enemy_damage_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | enemy_damage_checker: counts enemies next to the player, applies damage   |
// | with a hit cooldown and flags player death.             Revision: 1.0     |
// +--------------------------------------------------------------------------+
module enemy_damage_checker #(
  parameter int         GRID_W     = 40,
  parameter int         GRID_H     = 30,
  parameter logic [2:0] ENEMY_CODE = 3'd4,
  parameter logic [7:0] MAX_HEALTH = 8'd100,
  parameter logic [7:0] DAMAGE     = 8'd10,
  parameter int         COOLDOWN   = 25000000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_start,
  output logic       o_done,
  input  logic       i_restore,
  input  logic [5:0] i_player_x,
  input  logic [4:0] i_player_y,
  output logic [5:0] o_grid_x,
  output logic [4:0] o_grid_y,
  input  logic [2:0] i_grid_out,
  output logic [7:0] o_health,
  output logic       o_player_dead,
  output logic       o_hit
);

  localparam int                c_CD_W    = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [c_CD_W-1:0] c_cd_load = c_CD_W'(COOLDOWN);
  localparam logic [5:0]        c_x_max   = 6'(GRID_W - 1);
  localparam logic [4:0]        c_y_max   = 5'(GRID_H - 1);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LATCH      = 4'd1,
    S_ADDR_UP    = 4'd2,
    S_READ_UP    = 4'd3,
    S_ADDR_RIGHT = 4'd4,
    S_READ_RIGHT = 4'd5,
    S_ADDR_DOWN  = 4'd6,
    S_READ_DOWN  = 4'd7,
    S_ADDR_LEFT  = 4'd8,
    S_READ_LEFT  = 4'd9,
    S_APPLY      = 4'd10,
    S_DONE       = 4'd11
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [5:0]        r_px;
  logic [4:0]        r_py;
  logic [2:0]        r_count;
  logic [7:0]        r_health;
  logic [c_CD_W-1:0] r_cooldown;

  logic       w_scan;
  logic       w_read;
  logic [1:0] w_dir;
  logic       w_in_range;
  logic [5:0] w_nx;
  logic [4:0] w_ny;
  logic       w_apply_hit;
  logic [10:0] w_dmg;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_scan = 1'b0;
    w_read = 1'b0;
    w_dir  = 2'd0;
    case (r_state)
      S_IDLE:       if (i_start) w_next = S_LATCH;
      S_LATCH:      w_next = S_ADDR_UP;
      S_ADDR_UP:    begin w_next = S_READ_UP;    w_scan = 1'b1; w_dir = 2'd0; end
      S_READ_UP:    begin w_next = S_ADDR_RIGHT; w_scan = 1'b1; w_dir = 2'd0; w_read = 1'b1; end
      S_ADDR_RIGHT: begin w_next = S_READ_RIGHT; w_scan = 1'b1; w_dir = 2'd1; end
      S_READ_RIGHT: begin w_next = S_ADDR_DOWN;  w_scan = 1'b1; w_dir = 2'd1; w_read = 1'b1; end
      S_ADDR_DOWN:  begin w_next = S_READ_DOWN;  w_scan = 1'b1; w_dir = 2'd2; end
      S_READ_DOWN:  begin w_next = S_ADDR_LEFT;  w_scan = 1'b1; w_dir = 2'd2; w_read = 1'b1; end
      S_ADDR_LEFT:  begin w_next = S_READ_LEFT;  w_scan = 1'b1; w_dir = 2'd3; end
      S_READ_LEFT:  begin w_next = S_APPLY;      w_scan = 1'b1; w_dir = 2'd3; w_read = 1'b1; end
      S_APPLY:      w_next = S_DONE;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Neighbour address; off-grid neighbours read address 0,0 and never count.
  always_comb begin
    w_nx       = r_px;
    w_ny       = r_py;
    w_in_range = 1'b0;
    case (w_dir)
      2'd0:    begin w_ny = r_py - 5'd1; w_in_range = (r_py != 5'd0);  end
      2'd1:    begin w_nx = r_px + 6'd1; w_in_range = (r_px < c_x_max); end
      2'd2:    begin w_ny = r_py + 5'd1; w_in_range = (r_py < c_y_max); end
      default: begin w_nx = r_px - 6'd1; w_in_range = (r_px != 6'd0);  end
    endcase
    w_in_range = w_in_range && w_scan && (r_px <= c_x_max) && (r_py <= c_y_max);
  end

  assign o_grid_x = w_in_range ? w_nx : 6'd0;
  assign o_grid_y = w_in_range ? w_ny : 5'd0;

  assign w_dmg       = 11'(r_count) * 11'(DAMAGE);
  assign w_apply_hit = (r_state == S_APPLY) && (r_count != 3'd0) &&
                       (r_cooldown == '0) && !i_restore;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_px       <= 6'd0;
      r_py       <= 5'd0;
      r_count    <= 3'd0;
      r_health   <= MAX_HEALTH;
      r_cooldown <= '0;
    end else begin
      if (r_state == S_LATCH) begin
        r_px    <= i_player_x;
        r_py    <= i_player_y;
        r_count <= 3'd0;
      end else if (w_read && w_in_range && (i_grid_out == ENEMY_CODE)) begin
        r_count <= r_count + 3'd1;
      end

      if (i_restore) begin
        r_health   <= MAX_HEALTH;
        r_cooldown <= '0;
      end else if (w_apply_hit) begin
        r_health   <= (w_dmg >= {3'b000, r_health}) ? 8'd0 : (r_health - w_dmg[7:0]);
        r_cooldown <= c_cd_load;
      end else if (r_cooldown != '0) begin
        r_cooldown <= r_cooldown - 1'b1;
      end
    end
  end

  assign o_done        = (r_state == S_DONE);
  assign o_hit         = w_apply_hit;
  assign o_health      = r_health;
  assign o_player_dead = (r_health == 8'd0);

endmodule
`default_nettype wire

// File: tb/tb_enemy_damage_checker.sv
`default_nettype none
// Testbench for enemy_damage_checker: directed scenarios plus randomized scans
// against a grid/health/cooldown reference model.
module tb_enemy_damage_checker;

  localparam int         GW  = 40;
  localparam int         GH  = 30;
  localparam int         CD  = 40;
  localparam logic [2:0] EN  = 3'd4;
  localparam int         MAXH = 100;
  localparam int         DMG  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       restore = 1'b0;
  logic       done, hit, dead;
  logic [5:0] px = 6'd0;
  logic [5:0] gx;
  logic [4:0] py = 5'd0;
  logic [4:0] gy;
  logic [2:0] gout = 3'd0;
  logic [7:0] health;

  enemy_damage_checker #(.COOLDOWN(CD)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_start      (start),
    .o_done       (done),
    .i_restore    (restore),
    .i_player_x   (px),
    .i_player_y   (py),
    .o_grid_x     (gx),
    .o_grid_y     (gy),
    .i_grid_out   (gout),
    .o_health     (health),
    .o_player_dead(dead),
    .o_hit        (hit)
  );

  always #5 clk = ~clk;

  logic [2:0] grid [GW][GH];
  bit         force_enemy = 1'b0;
  longint     cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (force_enemy)                          gout <= EN;
    else if (int'(gx) < GW && int'(gy) < GH)  gout <= grid[gx][gy];
    else                                      gout <= 3'd0;
  end

  int     checks = 0;
  int     fails  = 0;
  int     m_health = MAXH;
  longint m_last_hit = -1000000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_grid();
    for (int x = 0; x < GW; x++)
      for (int y = 0; y < GH; y++)
        grid[x][y] = 3'd0;
  endtask

  function automatic bit nb(input int x, input int y, input int d, output int nx, output int ny);
    int dx [4] = '{0, 1, 0, -1};
    int dy [4] = '{-1, 0, 1, 0};
    nx = x + dx[d];
    ny = y + dy[d];
    return (nx >= 0) && (nx < GW) && (ny >= 0) && (ny < GH);
  endfunction

  task automatic surround(input int x, input int y, input int mask);
    int nx, ny;
    for (int d = 0; d < 4; d++)
      if (mask[d] && nb(x, y, d, nx, ny)) grid[nx][ny] = EN;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_restore();
    @(negedge clk);
    restore = 1'b1;
    @(negedge clk);
    restore = 1'b0;
    m_health   = MAXH;
    m_last_hit = -1000000;
  endtask

  // One full scan; checks addresses, hit, done timing and resulting health.
  task automatic do_scan(input int x, input int y, input bit rs, input bit hold);
    int  n, nx, ny;
    bit  ok, exp_hit;
    int  exp_addr;
    n = 0;
    @(negedge clk);
    px = 6'(x);
    py = 5'(y);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (!hold || k >= 11) start = 1'b0;
      if (k == 2) begin
        px = 6'($urandom);
        py = 5'($urandom);
      end
      if (k == 2 || k == 4 || k == 6 || k == 8) begin
        ok = nb(x, y, (k - 2) / 2, nx, ny);
        exp_addr = ok ? ((nx << 5) | ny) : 0;
        check("addr", 32'({gx, gy}), 32'(exp_addr));
        if (ok && (force_enemy || grid[nx][ny] == EN)) n++;
      end
      if (k == 10) begin
        if (rs) restore = 1'b1;
        #1;
        exp_hit = !rs && (n > 0) && (cyc >= m_last_hit + 1 + CD);
        check("hit", 32'(hit), 32'(exp_hit));
        check("done_early", 32'(done), 32'd0);
        if (rs) begin
          m_health   = MAXH;
          m_last_hit = -1000000;
        end else if (exp_hit) begin
          m_health   = (m_health > n * DMG) ? m_health - n * DMG : 0;
          m_last_hit = cyc;
        end
      end
      if (k == 11) begin
        restore = 1'b0;
        check("done", 32'(done), 32'd1);
        check("health", 32'(health), 32'(m_health));
        check("dead", 32'(dead), 32'(m_health == 0));
      end
      if (k == 12) check("done_off", 32'(done), 32'd0);
    end
  endtask

  task automatic reset_mid_scan(input int x, input int y);
    bit seen;
    @(negedge clk);
    px = 6'(x);
    py = 5'(y);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("rst_addr", 32'({gx, gy}), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_health   = MAXH;
    m_last_hit = -1000000;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("rst_no_done", 32'(seen), 32'd0);
    check("rst_health", 32'(health), 32'(MAXH));
  endtask

  initial begin
    clear_grid();
    idle(2);
    rst = 1'b0;
    #1;
    check("reset_done", 32'(done), 32'd0);
    check("reset_hit", 32'(hit), 32'd0);
    check("reset_addr", 32'({gx, gy}), 32'd0);
    check("reset_health", 32'(health), 32'(MAXH));
    check("reset_dead", 32'(dead), 32'd0);

    // single enemy above the player
    grid[10][9] = EN;
    do_scan(10, 10, 0, 0);
    check("t1_health", 32'(health), 32'd90);

    // four enemies, then an immediate rescan inside the cooldown
    do_restore();
    clear_grid();
    surround(20, 15, 4'hF);
    do_scan(20, 15, 0, 0);
    check("t2_health", 32'(health), 32'd60);
    do_scan(20, 15, 0, 0);
    check("t2_cooldown", 32'(health), 32'd60);

    // corner: only RIGHT and DOWN are on the grid
    do_restore();
    force_enemy = 1'b1;
    do_scan(0, 0, 0, 0);
    force_enemy = 1'b0;
    check("t3_health", 32'(health), 32'd80);

    // drive health down to zero with saturation
    do_restore();
    clear_grid();
    surround(5, 5, 4'hF);
    do_scan(5, 5, 0, 0);
    idle(CD + 2);
    do_scan(5, 5, 0, 0);
    check("t4_h20", 32'(health), 32'd20);
    clear_grid();
    surround(5, 5, 4'h1);
    idle(CD + 2);
    do_scan(5, 5, 0, 0);
    check("t4_h10", 32'(health), 32'd10);
    surround(5, 5, 4'h3);
    idle(CD + 2);
    do_scan(5, 5, 0, 0);
    check("t4_zero", 32'(health), 32'd0);
    check("t4_dead", 32'(dead), 32'd1);
    idle(CD + 2);
    do_scan(5, 5, 0, 0);
    check("t4_stay0", 32'(health), 32'd0);

    // restore in the APPLY cycle
    do_restore();
    do_scan(5, 5, 1, 0);
    check("t5_health", 32'(health), 32'(MAXH));

    // reset during READ_RIGHT, then start held high during a whole scan
    reset_mid_scan(5, 5);
    clear_grid();
    surround(GW - 1, GH - 1, 4'hF);
    do_scan(GW - 1, GH - 1, 0, 1);
    check("t6_health", 32'(health), 32'd80);

    // randomized scans
    for (int it = 0; it < 30; it++) begin
      int x, y;
      for (int gx_i = 0; gx_i < GW; gx_i++)
        for (int gy_i = 0; gy_i < GH; gy_i++)
          grid[gx_i][gy_i] = ($urandom_range(0, 2) == 0) ? EN : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       x = 0;
        1:       x = GW - 1;
        default: x = $urandom_range(0, GW - 1);
      endcase
      case ($urandom_range(0, 3))
        0:       y = 0;
        1:       y = GH - 1;
        default: y = $urandom_range(0, GH - 1);
      endcase
      if ($urandom_range(0, 7) == 0) do_restore();
      do_scan(x, y, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 50));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
